// File: rtl/deserializer.sv
// Rebuilds MSB-first serial bursts into MSB-aligned parallel words plus bit count.
// Latency: full word strobes 1 cycle after its last bit, partial word 2 cycles; no back-pressure.
module deserializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
);

  localparam int CNT_W = DATA_MOD_WIDTH + 1;

  typedef enum logic {IDLE_S, RECV_S} state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_BUS_WIDTH-1:0] buf_q;
  logic [DATA_BUS_WIDTH-1:0] data_q;
  logic [DATA_MOD_WIDTH-1:0] mod_q;
  logic                      val_q;

  logic [DATA_MOD_WIDTH-1:0] idx;
  logic [DATA_BUS_WIDTH-1:0] word_d;

  // Bit k of a word lands at W-1-k, which is the bitwise inverse of the count.
  assign idx = ~cnt_q[DATA_MOD_WIDTH-1:0];

  always_comb begin
    word_d      = (state_q == IDLE_S) ? '0 : buf_q;
    word_d[idx] = ser_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      val_q <= 1'b0;
      case (state_q)
        IDLE_S: begin
          if (ser_data_val_i) begin
            buf_q   <= word_d;
            cnt_q   <= CNT_W'(1);
            state_q <= RECV_S;
          end
        end
        RECV_S: begin
          if (ser_data_val_i) begin
            if (cnt_q == CNT_W'(DATA_BUS_WIDTH - 1)) begin
              data_q  <= word_d;
              mod_q   <= '0;
              val_q   <= 1'b1;
              buf_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE_S;
            end else begin
              buf_q <= word_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // Runts of 1 or 2 bits are illegal on the link and are dropped.
            if (cnt_q >= CNT_W'(3)) begin
              data_q <= buf_q;
              mod_q  <= cnt_q[DATA_MOD_WIDTH-1:0];
              val_q  <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= IDLE_S;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE_S;
        end
      endcase
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Directed and loopback-style stimulus with an expected-strobe queue checked by a monitor.
module tb_deserializer;

  logic        clk;
  logic        srst_i;
  logic        ser_data_i;
  logic        ser_data_val_i;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;

  deserializer #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) dut (
    .clk_i            (clk),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int busy_total = 0;
  always @(negedge clk) if (busy_o === 1'b1) busy_total <= busy_total + 1;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model of the word under collection.
  int          m_cnt = 0;
  logic [15:0] m_cur = '0;

  task automatic push_exp(input logic [15:0] d, input logic [3:0] m, input int c);
    exp_t e;
    e.d = d; e.m = m; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk); #1;
    ser_data_i     = b;
    ser_data_val_i = 1'b1;
    m_cur[15-m_cnt] = b;
    m_cnt++;
    if (m_cnt == 16) begin
      push_exp(m_cur, 4'd0, cyc + 1);
      m_cnt = 0;
      m_cur = '0;
    end
  endtask

  task automatic burst(input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) drive_bit(bits[n-1-k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ser_data_val_i = 1'b0;
      ser_data_i     = 1'b1;
      if (k == 0) begin
        if (m_cnt >= 3) push_exp(m_cur, 4'(m_cnt), cyc + 1);
        m_cnt = 0;
        m_cur = '0;
      end
    end
  endtask

  initial begin
    int   b0;
    int   mv;
    int   n;
    logic [31:0] w;
    srst_i         = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (deser_data_val_o !== 1'b0) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: got data=%h mod=%0d at cyc %0d, required no strobe",
                     deser_data_o, deser_data_mod_o, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (deser_data_o !== e.d || deser_data_mod_o !== e.m || cyc != e.c) begin
              n_err++;
              $display("FAIL strobe: got data=%h mod=%0d cyc=%0d, required data=%h mod=%0d cyc=%0d",
                       deser_data_o, deser_data_mod_o, cyc, e.d, e.m, e.c);
            end
          end
        end
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_val", {31'b0, deser_data_val_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_data", {16'b0, deser_data_o}, 32'd0);
        check("rst_mod", {28'b0, deser_data_mod_o}, 32'd0);
        @(posedge clk); #1 srst_i = 1'b1;
        idle(2);

        // Full word, then a 5-bit partial word.
        burst(32'hA5C3, 16);
        idle(3);
        b0 = busy_total;
        burst(32'b10110, 5);
        idle(3);
        check("busy_cycles", 32'(busy_total - b0), 32'd5);

        // Runts produce nothing and outputs hold.
        burst(32'b11, 2);
        idle(2);
        burst(32'b1, 1);
        idle(3);
        check("hold_data", {16'b0, deser_data_o}, 32'hB000);
        check("hold_mod", {28'b0, deser_data_mod_o}, 32'd5);
        check("hold_busy", {31'b0, busy_o}, 32'd0);

        // Long burst spanning two words.
        burst(32'hFFFF9, 20);
        idle(3);

        // Reset mid-burst.
        burst(32'h1FF, 9);
        @(posedge clk); #1;
        srst_i = 1'b0;
        ser_data_val_i = 1'b0;
        m_cnt = 0;
        m_cur = '0;
        @(posedge clk); #1 srst_i = 1'b1;
        @(negedge clk);
        check("mrst_busy", {31'b0, busy_o}, 32'd0);
        check("mrst_val", {31'b0, deser_data_val_o}, 32'd0);
        check("mrst_data", {16'b0, deser_data_o}, 32'd0);
        check("mrst_mod", {28'b0, deser_data_mod_o}, 32'd0);
        idle(3);
        check("mrst_quiet", {31'b0, busy_o}, 32'd0);
        burst(32'hC3, 8);
        idle(3);

        // Serializer-style traffic: mod in {0,3..15}, random gaps.
        for (int i = 0; i < 200; i++) begin
          mv = $urandom_range(0, 13);
          if (mv != 0) mv = mv + 2;
          n = (mv == 0) ? 16 : mv;
          w = 32'($urandom_range(0, 65535));
          burst(w >> (16 - n), n);
          idle($urandom_range(1, 3));
        end
        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    join
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream companion of the serializer: collects the serial bit stream (MSB first, valid-qualified) and rebuilds the parallel word plus its bit count (data_mod).
- Sits at the receive end of the serial link.
- Output format matches the serializer's input format, so the two blocks loop back bit-exactly.

Parameters:
DATA_BUS_WIDTH, 16, width of the rebuilt parallel word; must be a power of two and at least 4.
DATA_MOD_WIDTH, 4, width of the mod field; equals log2(DATA_BUS_WIDTH).

Ports:
clk_i  input  1  clock; all logic runs on the rising edge.
srst_i  input  1  synchronous, active-low reset.
ser_data_i  input  1  serial data bit; valid only while ser_data_val_i=1.
ser_data_val_i  input  1  serial valid; one bit per cycle while high.
deser_data_o  output  DATA_BUS_WIDTH  rebuilt word, MSB-aligned; unreceived LSBs are 0.
deser_data_mod_o  output  DATA_MOD_WIDTH  number of bits received; 0 means a full DATA_BUS_WIDTH word.
deser_data_val_o  output  1  single-cycle strobe qualifying deser_data_o and deser_data_mod_o.
busy_o  output  1  high while a word is being collected.

Behaviour:
- Reset: while srst_i=0 at a rising edge:
  - state goes to IDLE_S and the bit counter clears.
  - deser_data_val_o=0, busy_o=0, deser_data_o=0, deser_data_mod_o=0.
  - Any partial word is dropped and no strobe is produced, including when reset arrives mid-burst.
- Burst: a maximal run of consecutive cycles with ser_data_val_i=1. The serializer guarantees at least one idle cycle between bursts. The block must still handle bursts longer than DATA_BUS_WIDTH.
- Bit counter: DATA_MOD_WIDTH+1 bits, counts bits received in the current word (0..DATA_BUS_WIDTH).
- Bit placement: the k-th bit of a word (k=0 first) is written to shift-buffer index DATA_BUS_WIDTH-1-k. The buffer is cleared at the start of each word.
- States:
  - IDLE_S, while busy_o=0:
    - ser_data_val_i=1: capture the bit at index W-1, counter=1, go to RECV_S.
  - RECV_S, while busy_o=1:
    - ser_data_val_i=1 and counter<W-1: capture the bit, counter+1.
    - ser_data_val_i=1 and counter==W-1: capture the last bit, emit a full word, counter=0, go to IDLE_S.
    - ser_data_val_i=0: end of burst. If counter>=3, emit a partial word with mod=counter. If counter is 1 or 2, discard silently (runt; sizes 1 and 2 are illegal on the link). Go to IDLE_S.
- Emit:
  - deser_data_o and deser_data_mod_o are registered, updated only on emit, and held until the next emit.
  - deser_data_val_o is high for exactly the one cycle after the emit edge.
- Full word: emitted in the same cycle that the W-th bit is captured. deser_data_val_o rises on the next edge, so latency is 1 cycle after the last bit. deser_data_mod_o=0.
- Partial word: emitted when the first cycle with ser_data_val_i=0 is seen. deser_data_val_o is therefore high 2 cycles after the last bit.
- Long burst: if ser_data_val_i stays 1 after a full word, the next bit starts a new word (IDLE_S→RECV_S path). No bit is lost, and the strobe for word n may coincide with the first bit of word n+1.
- Data bits sampled while ser_data_val_i=0 are ignored.
- No back-pressure: the consumer must accept every strobe.
- No X may reach the outputs after reset.

Test Plan:
1. Serialize 16 bits of 0xA5C3 MSB first, then one idle cycle → one strobe 1 cycle after the last bit, data 0xA5C3, mod 0.
2. 5-bit burst 1,0,1,1,0 then idle → strobe 2 cycles after the last bit, data 0xB000, mod 5; busy_o high for exactly 5 cycles.
3. 2-bit burst 1,1 then a 1-bit burst 1, separated by idle → no strobe; outputs keep their prior values.
4. Continuous 20-bit burst (16 bits of 0xFFFF, then 1,0,0,1), then idle → strobe with 0xFFFF/mod 0, then strobe with 0x9000/mod 4; no bits lost.
5. Drive srst_i=0 for one cycle after 9 bits of a burst, then stay idle → no strobe, busy_o=0, outputs 0. A following 8-bit burst 0xC3 yields 0xC300, mod 8.
6. Loopback with the serializer: 200 random words (data_mod in {0,3..15}) with random gaps → every strobe equals the input word masked to its top mod bits, with the same mod value, in the same order.
